// File: rtl/vga_text_console.sv
// vga_text_console
// Writable character buffer for the VGA text path. Bytes arrive on a
// valid/ready port and are placed at a cursor that understands LF, CR and BS.
// When the cursor runs past the last row, the screen scrolls up by one row and
// the freed row is blanked. The glyph generator reads cells through a
// registered random-access port that is independent of the update state machine.

module vga_text_console #(
   parameter int COLS = 12,
   parameter int ROWS = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [7:0]              wr_char,
   input  logic                    clr,
   input  logic [$clog2(COLS)-1:0] rd_col,
   input  logic [$clog2(ROWS)-1:0] rd_row,
   output logic [7:0]              rd_char,
   output logic [$clog2(COLS)-1:0] cur_col,
   output logic [$clog2(ROWS)-1:0] cur_row,
   output logic                    busy
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int N  = COLS * ROWS;
   localparam int PW = $clog2(N);

   localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
   localparam logic [PW-1:0] ROW1_IDX = PW'(COLS);
   localparam logic [PW-1:0] LROW_IDX = PW'((ROWS - 1) * COLS);
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

   localparam logic [7:0] CH_NUL = 8'h00;
   localparam logic [7:0] CH_BS  = 8'h08;
   localparam logic [7:0] CH_LF  = 8'h0A;
   localparam logic [7:0] CH_CR  = 8'h0D;

   typedef enum logic [1:0] {
      ST_CLEAR   = 2'd0,
      ST_IDLE    = 2'd1,
      ST_SCROLL  = 2'd2,
      ST_CLR_ROW = 2'd3
   } state_t;

   // Update state machine registers
   state_t        state_r;
   logic [PW-1:0] ptr_r;
   logic [CW-1:0] col_r;
   logic [RW-1:0] row_r;

   // Character storage: deliberately not reset, the CLEAR sweep initialises it
   logic [7:0]    mem_r [N];

   // Single write port into the array, decoded from state and input
   logic          mem_we_s;
   logic [PW-1:0] mem_waddr_s;
   logic [7:0]    mem_wdata_s;

   // Misc decode
   logic          accept_s;
   logic [PW-1:0] cur_idx_s;
   logic [PW-1:0] rd_idx_s;
   logic          rd_in_range_s;
   logic [7:0]    rd_char_r;

   assign wr_ready = (state_r == ST_IDLE) && !clr;
   assign busy     = (state_r != ST_IDLE);
   assign accept_s = wr_valid && wr_ready;
   assign cur_col  = col_r;
   assign cur_row  = row_r;
   assign rd_char  = rd_char_r;

   assign cur_idx_s     = PW'(row_r) * PW'(COLS) + PW'(col_r);
   assign rd_idx_s      = PW'(rd_row) * PW'(COLS) + PW'(rd_col);
   assign rd_in_range_s = ({1'b0, rd_col} < (CW + 1)'(COLS)) &&
                          ({1'b0, rd_row} < (RW + 1)'(ROWS));

   // Decode the one array write performed this cycle (clear sweep, scroll copy, row blank, or CPU byte)
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = ptr_r;
      mem_wdata_s = CH_NUL;
      if (clr) begin
         // The sweep restarts from index 0, so any write this cycle is pointless
         mem_we_s = 1'b0;
      end else begin
         case (state_r)
            ST_CLEAR, ST_CLR_ROW: begin
               mem_we_s    = 1'b1;
               mem_waddr_s = ptr_r;
               mem_wdata_s = CH_NUL;
            end
            ST_SCROLL: begin
               // Move one cell up a full row; the source is read combinationally
               mem_we_s    = 1'b1;
               mem_waddr_s = ptr_r - ROW1_IDX;
               mem_wdata_s = mem_r[ptr_r];
            end
            ST_IDLE: begin
               if (accept_s) begin
                  case (wr_char)
                     CH_LF, CH_CR: begin
                        mem_we_s = 1'b0;
                     end
                     CH_BS: begin
                        if (col_r != {CW{1'b0}}) begin
                           mem_we_s    = 1'b1;
                           mem_waddr_s = cur_idx_s - PW'(1);
                           mem_wdata_s = CH_NUL;
                        end else begin
                           mem_we_s = 1'b0;
                        end
                     end
                     default: begin
                        // Every other code, NUL included, is stored verbatim
                        mem_we_s    = 1'b1;
                        mem_waddr_s = cur_idx_s;
                        mem_wdata_s = wr_char;
                     end
                  endcase
               end else begin
                  mem_we_s = 1'b0;
               end
            end
            default: begin
               mem_we_s = 1'b0;
            end
         endcase
      end
   end

   // Character array write port
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[mem_waddr_s] <= mem_wdata_s;
      end
   end

   // Console state machine: clear sweep, byte/cursor handling, scroll copy and last-row blanking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_CLEAR;
         ptr_r   <= {PW{1'b0}};
         col_r   <= {CW{1'b0}};
         row_r   <= {RW{1'b0}};
      end else if (clr) begin
         // Clear wins over everything, including a pending byte and a partial scroll
         state_r <= ST_CLEAR;
         ptr_r   <= {PW{1'b0}};
         col_r   <= {CW{1'b0}};
         row_r   <= {RW{1'b0}};
      end else begin
         case (state_r)
            ST_CLEAR: begin
               col_r <= {CW{1'b0}};
               row_r <= {RW{1'b0}};
               if (ptr_r == LAST_IDX) begin
                  state_r <= ST_IDLE;
                  ptr_r   <= {PW{1'b0}};
               end else begin
                  ptr_r <= ptr_r + PW'(1);
               end
            end
            ST_IDLE: begin
               if (accept_s) begin
                  case (wr_char)
                     CH_LF: begin
                        col_r <= {CW{1'b0}};
                        if (row_r == LAST_ROW) begin
                           state_r <= ST_SCROLL;
                           ptr_r   <= ROW1_IDX;
                        end else begin
                           row_r <= row_r + RW'(1);
                        end
                     end
                     CH_CR: begin
                        col_r <= {CW{1'b0}};
                     end
                     CH_BS: begin
                        if (col_r != {CW{1'b0}}) begin
                           col_r <= col_r - CW'(1);
                        end
                     end
                     default: begin
                        if (col_r == LAST_COL) begin
                           col_r <= {CW{1'b0}};
                           if (row_r == LAST_ROW) begin
                              state_r <= ST_SCROLL;
                              ptr_r   <= ROW1_IDX;
                           end else begin
                              row_r <= row_r + RW'(1);
                           end
                        end else begin
                           col_r <= col_r + CW'(1);
                        end
                     end
                  endcase
               end
            end
            ST_SCROLL: begin
               if (ptr_r == LAST_IDX) begin
                  state_r <= ST_CLR_ROW;
                  ptr_r   <= LROW_IDX;
               end else begin
                  ptr_r <= ptr_r + PW'(1);
               end
            end
            ST_CLR_ROW: begin
               if (ptr_r == LAST_IDX) begin
                  state_r <= ST_IDLE;
                  ptr_r   <= {PW{1'b0}};
               end else begin
                  ptr_r <= ptr_r + PW'(1);
               end
            end
            default: begin
               state_r <= ST_CLEAR;
               ptr_r   <= {PW{1'b0}};
            end
         endcase
      end
   end

   // Display read port: one-cycle registered lookup, blank outside the screen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_char_r <= CH_NUL;
      end else if (rd_in_range_s) begin
         rd_char_r <= mem_r[rd_idx_s];
      end else begin
         rd_char_r <= CH_NUL;
      end
   end

endmodule

// File: tb/tb_vga_text_console.sv
// Scoreboard bench for vga_text_console (12x3 default geometry).
// Stimulus tasks push expected read data / status into queues; a monitor
// process pops and compares when the DUT presents the corresponding output.
`timescale 1ns/1ps

module tb_vga_text_console;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_char  = 8'h00;
   logic       clr      = 1'b0;
   logic [3:0] rd_col   = 4'd0;
   logic [1:0] rd_row   = 2'd0;
   logic       wr_ready;
   logic [7:0] rd_char;
   logic [3:0] cur_col;
   logic [1:0] cur_row;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t rd_q[$];
   exp_t st_q[$];
   logic rd_req   = 1'b0;
   logic rd_req_q = 1'b0;
   logic st_req   = 1'b0;

   logic [7:0] hello [5];

   vga_text_console #(.COLS(12), .ROWS(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_char  (wr_char),
      .clr      (clr),
      .rd_col   (rd_col),
      .rd_row   (rd_row),
      .rd_char  (rd_char),
      .cur_col  (cur_col),
      .cur_row  (cur_row),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // A read request issued before edge k produces rd_char after edge k
   always @(posedge clk) rd_req_q <= rd_req;

   // Monitor: compare DUT outputs against queued expectations mid-cycle
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rd_req_q) begin
         if (rd_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rd_scoreboard: read data presented with no expectation queued");
         end else begin
            e = rd_q.pop_front();
            check(e.name, {24'h0, rd_char}, e.exp);
         end
      end
      if (st_req) begin
         if (st_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL st_scoreboard: status sample with no expectation queued");
         end else begin
            e = st_q.pop_front();
            check(e.name, {24'h0, busy, wr_ready, cur_row, cur_col}, e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int r, input int c, input logic [7:0] exp);
      exp_t e;
      e.exp  = {24'h0, exp};
      e.name = $sformatf("rd(%0d,%0d)", r, c);
      rd_row = r[1:0];
      rd_col = c[3:0];
      rd_q.push_back(e);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   // Expected status: {busy, wr_ready, cur_row, cur_col}
   task automatic st(input string name, input logic b, input logic rdy, input int row, input int col);
      exp_t e;
      e.exp  = {24'h0, b, rdy, row[1:0], col[3:0]};
      e.name = name;
      st_q.push_back(e);
      st_req = 1'b1;
      tick();
      st_req = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, inout int waits);
      int budget;
      bit done;
      budget   = 0;
      done     = 1'b0;
      wr_valid = 1'b1;
      wr_char  = b;
      while (!done) begin
         @(negedge clk);
         if (wr_ready) begin
            done = 1'b1;
         end else begin
            waits++;
            budget++;
            if (budget > 200) begin
               n_checks++;
               n_errors++;
               $display("FAIL send_timeout: byte 0x%0h not accepted after %0d cycles, required < 200", b, budget);
               done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   // Count busy cycles until idle; also count cycles where wr_ready fails to be !busy
   task automatic wait_idle(output int cyc, output int bad);
      bit done;
      cyc  = 0;
      bad  = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (wr_ready == busy) bad++;
         if (!busy) begin
            done = 1'b1;
         end else begin
            cyc++;
            if (cyc > 200) begin
               n_checks++;
               n_errors++;
               $display("FAIL idle_timeout: busy still high after %0d cycles, required 36", cyc);
               done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      int cyc;
      int bad;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      wait_idle(cyc, bad);
      check("clear_cycles", cyc, 36);
      check("clear_ready_vs_busy", bad, 0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int waits;
      int cyc;
      int bad;

      hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

      // ---- reset state ----
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      st("reset_status", 1'b1, 1'b0, 0, 0);
      rd(0, 0, 8'h00);
      rst_n = 1'b1;
      wait_idle(cyc, bad);
      check("reset_clear_cycles", cyc, 36);
      check("reset_ready_vs_busy", bad, 0);
      st("after_reset_clear", 1'b0, 1'b1, 0, 0);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 12; c++)
            rd(r, c, 8'h00);
      rd(3, 0, 8'h00);
      rd(3, 11, 8'h00);
      rd(0, 12, 8'h00);
      rd(2, 15, 8'h00);

      // ---- HELLO back-to-back ----
      waits = 0;
      for (int i = 0; i < 5; i++) send(hello[i], waits);
      check("hello_waits", waits, 0);
      st("hello_cursor", 1'b0, 1'b1, 0, 5);
      for (int i = 0; i < 5; i++) rd(0, i, hello[i]);
      rd(0, 5, 8'h00);

      // ---- row wrap, CR, BS ----
      do_clear();
      waits = 0;
      for (int i = 0; i < 12; i++) send(8'h41 + 8'(i), waits);
      check("wrap_waits", waits, 0);
      st("wrap_cursor", 1'b0, 1'b1, 1, 0);
      for (int i = 0; i < 12; i++) rd(0, i, 8'h41 + 8'(i));
      send(8'h78, waits);
      send(8'h79, waits);
      send(8'h7A, waits);
      st("xyz_cursor", 1'b0, 1'b1, 1, 3);
      send(8'h0D, waits);
      st("cr_cursor", 1'b0, 1'b1, 1, 0);
      send(8'h08, waits);
      st("bs_col0_cursor", 1'b0, 1'b1, 1, 0);
      rd(1, 0, 8'h78);
      send(8'h71, waits);
      rd(1, 0, 8'h71);
      st("q_cursor", 1'b0, 1'b1, 1, 1);
      send(8'h08, waits);
      st("bs_cursor", 1'b0, 1'b1, 1, 0);
      rd(1, 0, 8'h00);
      rd(1, 1, 8'h79);

      // ---- fill screen, 36th byte scrolls ----
      do_clear();
      waits = 0;
      for (int i = 0; i < 36; i++)
         send((i < 12) ? 8'h41 : (i < 24) ? 8'h42 : 8'h43, waits);
      check("fill_waits", waits, 0);
      wait_idle(cyc, bad);
      check("scroll_cycles", cyc, 36);
      check("scroll_ready_vs_busy", bad, 0);
      st("scroll_cursor", 1'b0, 1'b1, 2, 0);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 12; c++)
            rd(r, c, (r == 0) ? 8'h42 : (r == 1) ? 8'h43 : 8'h00);
      rd(0, 12, 8'h00);
      rd(0, 13, 8'h00);
      rd(3, 0, 8'h00);
      rd(3, 2, 8'h00);

      // ---- LF on last row scrolls ----
      for (int i = 0; i < 5; i++) send(8'h31 + 8'(i), waits);
      st("digits_cursor", 1'b0, 1'b1, 2, 5);
      send(8'h0A, waits);
      wait_idle(cyc, bad);
      check("lf_scroll_cycles", cyc, 36);
      st("lf_cursor", 1'b0, 1'b1, 2, 0);
      for (int c = 0; c < 12; c++) rd(0, c, 8'h43);
      for (int c = 0; c < 12; c++) rd(1, c, (c < 5) ? 8'h31 + 8'(c) : 8'h00);
      for (int c = 0; c < 12; c++) rd(2, c, 8'h00);
      send(8'h58, waits);
      rd(2, 0, 8'h58);
      st("x_cursor", 1'b0, 1'b1, 2, 1);
      send(8'h08, waits);
      st("x_bs_cursor", 1'b0, 1'b1, 2, 0);
      rd(2, 0, 8'h00);

      // ---- clr mid-scroll with a byte held ----
      for (int i = 0; i < 12; i++) send(8'h5A, waits);
      repeat (5) tick();
      clr      = 1'b1;
      wr_valid = 1'b1;
      wr_char  = 8'h57;
      tick();
      clr = 1'b0;
      wait_idle(cyc, bad);
      wr_valid = 1'b0;
      check("clr_scroll_cycles", cyc, 36);
      check("clr_scroll_ready_vs_busy", bad, 0);
      st("held_byte_cursor", 1'b0, 1'b1, 0, 1);
      rd(0, 0, 8'h57);
      rd(0, 1, 8'h00);
      rd(1, 0, 8'h00);
      rd(1, 5, 8'h00);
      rd(2, 0, 8'h00);
      rd(2, 11, 8'h00);

      // ---- clr beats wr_valid in IDLE ----
      clr      = 1'b1;
      wr_valid = 1'b1;
      wr_char  = 8'h56;
      @(negedge clk);
      check("clr_priority_ready", wr_ready, 0);
      @(posedge clk);
      #1;
      clr      = 1'b0;
      wr_valid = 1'b0;
      wait_idle(cyc, bad);
      check("clr_idle_cycles", cyc, 36);
      st("clr_idle_cursor", 1'b0, 1'b1, 0, 0);
      rd(0, 0, 8'h00);
      rd(0, 1, 8'h00);

      // drain the scoreboard
      tick();
      tick();
      if (rd_q.size() != 0 || st_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: %0d reads and %0d status entries left, expected 0", rd_q.size(), st_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
